zoom_auto_sequencer: RTL and testbench

//   Consumes the 1-cycle tick from the 50 MHz tick generator (one pulse per 0.5 s) and steps the

---
 rtl/zoom_auto_sequencer.sv | 145 ++++++++++++++
 tb/tb_zoom_auto_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zoom_auto_sequencer.sv
// Digital-zoom level sequencer.
// Steps the zoom level from manual up/down pulses or, in auto mode, ping-pongs between
// MIN_LEVEL and MAX_LEVEL once every DWELL_TICKS ticks. Each new level is offered to the
// scaler with a req/ack handshake; a missing ack aborts after ACK_TIMEOUT cycles, but the
// new level stays committed.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no handshake open; manual and auto events are accepted
//   REQ   | level_out offered to scaler, waiting for ack or timeout
module zoom_auto_sequencer #(
    parameter int LEVEL_W     = 3,
    parameter int MIN_LEVEL   = 0,
    parameter int MAX_LEVEL   = 4,
    parameter int DWELL_TICKS = 2,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic               clk_50mhz,
    input  logic               rst_n,
    input  logic               tick_in,
    input  logic               auto_en,
    input  logic               man_up,
    input  logic               man_down,
    input  logic               ack,
    output logic [LEVEL_W-1:0] level_out,
    output logic               dir_up,
    output logic               req,
    output logic               timeout_err
);

    localparam int DW_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam int TO_W = $clog2(ACK_TIMEOUT);

    localparam logic [LEVEL_W:0] LV_MIN  = MIN_LEVEL[LEVEL_W:0];
    localparam logic [LEVEL_W:0] LV_MAX  = MAX_LEVEL[LEVEL_W:0];
    localparam logic [DW_W-1:0]  DW_LAST = DW_W'(DWELL_TICKS - 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    // With a single allowed level an auto step has nowhere to go.
    localparam bit               SINGLE  = (MIN_LEVEL == MAX_LEVEL);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t             r_state;
    logic [LEVEL_W-1:0] r_level;
    logic               r_dir_up;
    logic               r_req;
    logic               r_timeout_err;
    logic [DW_W-1:0]    r_dwell_cnt;
    logic [TO_W-1:0]    r_to_cnt;

    // Targets carry one extra bit so that 0-1 and 2^LEVEL_W-1 + 1 fall out of range.
    logic [LEVEL_W:0]   w_lvl;
    logic [LEVEL_W:0]   w_man_tgt;
    logic               w_man_ok;
    logic [LEVEL_W:0]   w_auto_tgt;
    logic               w_auto_dir;

    assign w_lvl     = {1'b0, r_level};
    assign w_man_tgt = man_up ? (w_lvl + 1'b1) : (w_lvl - 1'b1);
    assign w_man_ok  = (w_man_tgt >= LV_MIN) && (w_man_tgt <= LV_MAX);

    // Next auto-sweep level and direction, bouncing off either end of the range.
    always_comb begin
        w_auto_dir = r_dir_up;
        w_auto_tgt = r_dir_up ? (w_lvl + 1'b1) : (w_lvl - 1'b1);
        if (r_dir_up && (w_lvl == LV_MAX)) begin
            w_auto_dir = 1'b0;
            w_auto_tgt = LV_MAX - 1'b1;
        end else if (!r_dir_up && (w_lvl == LV_MIN)) begin
            w_auto_dir = 1'b1;
            w_auto_tgt = LV_MIN + 1'b1;
        end
    end

    // Sequencer FSM with registered outputs, dwell counter and handshake timeout counter.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_level       <= LV_MIN[LEVEL_W-1:0];
            r_dir_up      <= 1'b1;
            r_req         <= 1'b0;
            r_timeout_err <= 1'b0;
            r_dwell_cnt   <= '0;
            r_to_cnt      <= '0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (man_up ^ man_down) begin
                        r_dwell_cnt <= '0;
                        if (w_man_ok) begin
                            r_level <= w_man_tgt[LEVEL_W-1:0];
                            r_req   <= 1'b1;
                            r_state <= REQ;
                        end
                    end else if (man_up & man_down) begin
                        // Conflicting manual request: the whole cycle is discarded.
                        r_dwell_cnt <= r_dwell_cnt;
                    end else if (auto_en & tick_in) begin
                        if (r_dwell_cnt == DW_LAST) begin
                            r_dwell_cnt <= '0;
                            if (!SINGLE) begin
                                r_dir_up <= w_auto_dir;
                                r_level  <= w_auto_tgt[LEVEL_W-1:0];
                                r_req    <= 1'b1;
                                r_state  <= REQ;
                            end
                        end else begin
                            r_dwell_cnt <= r_dwell_cnt + 1'b1;
                        end
                    end else if (!auto_en) begin
                        r_dwell_cnt <= '0;
                    end
                end
                REQ: begin
                    if (ack) begin
                        r_req    <= 1'b0;
                        r_to_cnt <= '0;
                        r_state  <= IDLE;
                    end else if (r_to_cnt == TO_LAST) begin
                        r_req         <= 1'b0;
                        r_timeout_err <= 1'b1;
                        r_to_cnt      <= '0;
                        r_state       <= IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign level_out   = r_level;
    assign dir_up      = r_dir_up;
    assign req         = r_req;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_zoom_auto_sequencer.sv
// Testbench for zoom_auto_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the zoom sequencing rules.
module tb_zoom_auto_sequencer;

    localparam int MIN_L   = 0;
    localparam int MAX_L   = 4;
    localparam int DWELL   = 2;
    localparam int TIMEOUT = 255;

    logic       clk_50mhz;
    logic       rst_n;
    logic       tick_in;
    logic       auto_en;
    logic       man_up;
    logic       man_down;
    logic       ack;
    logic [2:0] level_out;
    logic       dir_up;
    logic       req;
    logic       timeout_err;

    zoom_auto_sequencer dut (
        .clk_50mhz   (clk_50mhz),
        .rst_n       (rst_n),
        .tick_in     (tick_in),
        .auto_en     (auto_en),
        .man_up      (man_up),
        .man_down    (man_down),
        .ack         (ack),
        .level_out   (level_out),
        .dir_up      (dir_up),
        .req         (req),
        .timeout_err (timeout_err)
    );

    initial begin
        clk_50mhz = 1'b0;
        forever #10 clk_50mhz = ~clk_50mhz;
    end

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: zoom level as a plain integer, a "handshake open" flag,
    // the age of the open handshake and the number of ticks seen toward the next step.
    int m_level;
    bit m_dir;
    bit m_busy;
    int m_age;
    int m_ticks;
    bit m_terr;

    // Handshake responder: when ack_mode is set, ack is raised once req is ack_delay cycles old.
    bit ack_mode  = 1'b0;
    int ack_delay = 2;

    bit      prev_req = 1'b0;
    int      rises    = 0;
    int      q_lv[$];
    bit      q_dir[$];
    int      req_hi_cycles = 0;
    int      terr_cycles   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_level = MIN_L;
        m_dir   = 1'b1;
        m_busy  = 1'b0;
        m_age   = 0;
        m_ticks = 0;
        m_terr  = 1'b0;
    endtask

    // One clock edge of the zoom rules, applied to the inputs present at that edge.
    task automatic model_edge();
        int t;
        m_terr = 1'b0;
        if (m_busy) begin
            if (ack) begin
                m_busy = 1'b0;
                m_age  = 0;
            end else begin
                m_age++;
                if (m_age == TIMEOUT) begin
                    m_busy = 1'b0;
                    m_terr = 1'b1;
                    m_age  = 0;
                end
            end
        end else if (man_up != man_down) begin
            m_ticks = 0;
            t = man_up ? m_level + 1 : m_level - 1;
            if (t >= MIN_L && t <= MAX_L) begin
                m_level = t;
                m_busy  = 1'b1;
            end
        end else if (man_up && man_down) begin
            m_ticks = m_ticks;
        end else if (auto_en && tick_in) begin
            m_ticks++;
            if (m_ticks == DWELL) begin
                m_ticks = 0;
                if (m_level == MAX_L && m_dir) m_dir = 1'b0;
                else if (m_level == MIN_L && !m_dir) m_dir = 1'b1;
                m_level = m_dir ? m_level + 1 : m_level - 1;
                m_busy  = 1'b1;
            end
        end else if (!auto_en) begin
            m_ticks = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".level"}, 32'(level_out), 32'(m_level));
        chk({tag, ".dir"}, 32'(dir_up), 32'(m_dir));
        chk({tag, ".req"}, 32'(req), 32'(m_busy));
        chk({tag, ".terr"}, 32'(timeout_err), 32'(m_terr));
    endtask

    // Advance one clock: inputs are already set; sample outputs 1 ns after the edge.
    task automatic cycle(input string tag);
        if (ack_mode) ack = m_busy && (m_age >= ack_delay - 1);
        @(posedge clk_50mhz);
        model_edge();
        #1;
        check_outputs(tag);
        if (req && !prev_req) begin
            rises++;
            q_lv.push_back(int'(level_out));
            q_dir.push_back(dir_up);
        end
        if (req) req_hi_cycles++;
        if (timeout_err) terr_cycles++;
        prev_req = req;
    endtask

    task automatic step(input string tag, input bit up, input bit dn, input bit tk);
        man_up   = up;
        man_down = dn;
        tick_in  = tk;
        cycle(tag);
        man_up   = 1'b0;
        man_down = 1'b0;
        tick_in  = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        prev_req = 1'b0;
    endtask

    int exp_lv[7]  = '{1, 2, 3, 4, 3, 2, 1};
    bit exp_dir[7] = '{1, 1, 1, 1, 0, 0, 0};

    initial begin
        rst_n    = 1'b0;
        tick_in  = 1'b0;
        auto_en  = 1'b0;
        man_up   = 1'b0;
        man_down = 1'b0;
        ack      = 1'b0;
        model_reset();
        #25;
        check_outputs("reset");
        #10;
        rst_n = 1'b1;
        idle("post_reset", 3);

        // T1: async reset while a handshake is open at level 3.
        ack_mode = 1'b1;
        ack_delay = 2;
        step("t1_up", 1'b1, 1'b0, 1'b0);
        idle("t1", 5);
        step("t1_up", 1'b1, 1'b0, 1'b0);
        idle("t1", 5);
        step("t1_up", 1'b1, 1'b0, 1'b0);
        chk("t1_pre_req", 32'(req), 32'd1);
        chk("t1_pre_level", 32'(level_out), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_async_req", 32'(req), 32'd0);
        chk("t1_async_level", 32'(level_out), 32'd0);
        chk("t1_async_dir", 32'(dir_up), 32'd1);
        model_reset();
        #2;
        rst_n = 1'b1;
        prev_req = 1'b0;
        idle("t1_after", 3);

        // T2: auto sweep, 14 ticks spaced well apart.
        rises = 0;
        q_lv.delete();
        q_dir.delete();
        auto_en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step("t2_tick", 1'b0, 1'b0, 1'b1);
            idle("t2", 7);
        end
        chk("t2_req_count", 32'(rises), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (i < q_lv.size()) begin
                chk($sformatf("t2_level%0d", i), 32'(q_lv[i]), 32'(exp_lv[i]));
                chk($sformatf("t2_dir%0d", i), 32'(q_dir[i]), 32'(exp_dir[i]));
            end else begin
                chk($sformatf("t2_missing%0d", i), 32'(q_lv.size()), 32'd7);
            end
        end

        // T3: manual steps at both ends of the range.
        auto_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("t3_up", 1'b1, 1'b0, 1'b0);
            idle("t3", 6);
        end
        chk("t3_at_max", 32'(level_out), 32'd4);
        step("t3_up_at_max", 1'b1, 1'b0, 1'b0);
        chk("t3_up_max_noreq", 32'(req), 32'd0);
        idle("t3", 2);
        step("t3_down", 1'b0, 1'b1, 1'b0);
        chk("t3_down_req", 32'(req), 32'd1);
        chk("t3_down_level", 32'(level_out), 32'd3);
        idle("t3", 6);
        for (int i = 0; i < 3; i++) begin
            step("t3_down", 1'b0, 1'b1, 1'b0);
            idle("t3", 6);
        end
        step("t3_down_at_min", 1'b0, 1'b1, 1'b0);
        chk("t3_down_min_noreq", 32'(req), 32'd0);
        chk("t3_min_level", 32'(level_out), 32'd0);

        // T4: collisions.
        step("t4_both", 1'b1, 1'b1, 1'b0);
        chk("t4_both_req", 32'(req), 32'd0);
        chk("t4_both_level", 32'(level_out), 32'd0);
        auto_en = 1'b1;
        step("t4_tick1", 1'b0, 1'b0, 1'b1);
        chk("t4_tick1_noreq", 32'(req), 32'd0);
        idle("t4", 2);
        step("t4_up_tick", 1'b1, 1'b0, 1'b1);
        chk("t4_manual_req", 32'(req), 32'd1);
        chk("t4_manual_level", 32'(level_out), 32'd1);
        idle("t4", 6);
        step("t4_tick_a", 1'b0, 1'b0, 1'b1);
        chk("t4_dwell_cleared", 32'(req), 32'd0);
        idle("t4", 2);
        step("t4_tick_b", 1'b0, 1'b0, 1'b1);
        chk("t4_auto_req", 32'(req), 32'd1);
        chk("t4_auto_level", 32'(level_out), 32'd0);
        idle("t4", 6);

        // T5: no ack -> timeout after exactly TIMEOUT cycles of req.
        auto_en = 1'b0;
        ack_mode = 1'b0;
        ack = 1'b0;
        idle("t5", 2);
        req_hi_cycles = 0;
        terr_cycles = 0;
        step("t5_up", 1'b1, 1'b0, 1'b0);
        idle("t5", 300);
        chk("t5_req_cycles", 32'(req_hi_cycles), 32'(TIMEOUT));
        chk("t5_terr_cycles", 32'(terr_cycles), 32'd1);
        chk("t5_level_kept", 32'(level_out), 32'd1);

        // T6: events while busy are dropped and the dwell count is frozen.
        step("t6_up", 1'b1, 1'b0, 1'b0);
        auto_en = 1'b1;
        step("t6_busy_up", 1'b1, 1'b0, 1'b0);
        step("t6_busy_tick", 1'b0, 1'b0, 1'b1);
        step("t6_busy_down", 1'b0, 1'b1, 1'b0);
        chk("t6_level_held", 32'(level_out), 32'd2);
        ack = 1'b1;
        step("t6_ack", 1'b0, 1'b0, 1'b0);
        ack = 1'b0;
        rises = 0;
        idle("t6", 10);
        chk("t6_no_extra_req", 32'(rises), 32'd0);
        step("t6_tick_a", 1'b0, 1'b0, 1'b1);
        chk("t6_dwell_frozen", 32'(req), 32'd0);
        idle("t6", 2);
        step("t6_tick_b", 1'b0, 1'b0, 1'b1);
        chk("t6_step_req", 32'(req), 32'd1);
        ack = 1'b1;
        idle("t6", 1);
        ack = 1'b0;

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
            ack = ($urandom_range(0, 3) == 0);
            if ((i / 1000) % 3 == 2) ack = ($urandom_range(0, 299) == 0);
            step("rand",
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
